// File: rtl/booth_mac_acc.sv
// Saturating MAC accumulator behind the Booth multiplier: sums a programmed
// number of signed products and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for start; acc_out keeps the last result
// ACCUM | accepting products until the term count reaches zero
// HOLD  | result presented on acc_out/acc_valid until acc_ready
module booth_mac_acc #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 10,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              sat,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf;
    logic             xfer;
    logic             last;

    // One guard bit is enough: a product never exceeds the accumulator range.
    assign prod_ext = (ACC_W+1)'($signed(prod));
    assign sum      = {acc[ACC_W-1], acc} + prod_ext;
    assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_nxt  = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == HOLD);
    assign busy       = (state != IDLE);
    assign xfer       = prod_valid && prod_ready;
    assign last       = xfer && (cnt == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            acc_out <= '0;
            sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        sat <= 1'b0;
                        cnt <= len;
                        if (len == '0) begin
                            acc_out <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= acc_nxt;
                        cnt <= cnt - LEN_W'(1);
                        if (ovf) begin
                            sat <= 1'b1;
                        end
                        if (last) begin
                            acc_out <= acc_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: expected results come from a small
// saturating model, queued at job start and checked when acc_valid appears.
module tb_booth_mac_acc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic [7:0] prod;
    logic       prod_valid;
    logic       prod_ready;
    logic [9:0] acc_out;
    logic       acc_valid;
    logic       acc_ready;
    logic       sat;
    logic       busy;

    typedef struct {
        int acc;
        bit sat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_cnt = 0;

    booth_mac_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .sat        (sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prod_ready === 1'b1) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int p[$]);
        exp_t e;
        e.acc = 0;
        e.sat = 1'b0;
        foreach (p[i]) begin
            e.acc += p[i];
            if (e.acc > 511) begin
                e.acc = 511;
                e.sat = 1'b1;
            end else if (e.acc < -512) begin
                e.acc = -512;
                e.sat = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic do_start(input int l);
        start = 1'b1;
        len   = 4'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int p);
        int t = 0;
        prod       = 8'(p);
        prod_valid = 1'b1;
        while (prod_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) chk("send_timeout", prod_ready, 1);
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    task automatic job(input string tag, input int p[$]);
        sb.push_back(model(p));
        do_start(p.size());
        foreach (p[i]) send(p[i]);
    endtask

    task automatic collect(input string tag, input bit start_in_hs);
        exp_t e;
        chk({tag, "_valid"}, acc_valid, 1);
        chk({tag, "_sb"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_acc"}, $signed(acc_out), e.acc);
            chk({tag, "_sat"}, sat, e.sat);
        end
        acc_ready = 1'b1;
        start     = start_in_hs;
        len       = 4'd3;
        @(negedge clk);
        acc_ready = 1'b0;
        start     = 1'b0;
        chk({tag, "_drop"}, acc_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int r0;
        rst_n = 1'b0; start = 1'b0; len = '0; prod = '0;
        prod_valid = 1'b0; acc_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_acc", $signed(acc_out), 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_ready", prod_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        r0 = rdy_cnt;
        job("dot", '{6, -12, 49, -56});
        chk("dot_ready_cycles", rdy_cnt - r0, 4);
        collect("dot", 1'b0);
        @(negedge clk);

        job("psat9", '{64, 64, 64, 64, 64, 64, 64, 64, 64});
        collect("psat9", 1'b0);
        @(negedge clk);
        job("p7", '{64, 64, 64, 64, 64, 64, 64});
        collect("p7", 1'b0);
        @(negedge clk);

        do_start(5);
        send(64); send(64); send(64);
        rst_n = 1'b0;
        #1;
        chk("abort_acc", $signed(acc_out), 0);
        chk("abort_valid", acc_valid, 0);
        chk("abort_ready", prod_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        job("post_rst", '{5, -3});
        collect("post_rst", 1'b0);
        @(negedge clk);

        job("nsat", '{-56, -56, -56, -56, -56, -56, -56, -56, -56, -56, 64, 64});
        collect("nsat", 1'b0);
        @(negedge clk);

        sb.push_back(model('{1, 2, 3}));
        do_start(3);
        prod = 8'd1; prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
        repeat (2) @(negedge clk);
        prod = 8'd2; prod_valid = 1'b1;
        @(negedge clk);
        prod = 8'd3;
        @(negedge clk);
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", acc_valid, 1);
            chk("bp_hold_acc", $signed(acc_out), 6);
            start = (i == 1 || i == 3);
            len   = 4'd2;
            @(negedge clk);
            start = 1'b0;
        end
        collect("bp", 1'b1);
        @(negedge clk);

        r0 = rdy_cnt;
        sb.push_back(model('{}));
        do_start(0);
        collect("zero", 1'b0);
        chk("zero_no_ready", rdy_cnt - r0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mac_acc.md
Name: booth_mac_acc

Overview:
- Downstream stage of the 4-bit signed Booth multiplier.
- Consumes a stream of signed 8-bit products over a valid/ready handshake and accumulates a programmed number of them into a saturating signed accumulator.
- Presents the final sum on a held output handshake.
- Turns the combinational multiplier into a dot-product / MAC engine.

Parameters:
- PROD_W, 8, width of incoming signed product (multiplier output c[7:0]).
- ACC_W, 10, width of signed accumulator and result.
- LEN_W, 4, width of term-count field; up to 2^LEN_W-1 terms per job.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a job; sampled only in IDLE.
- len  input  LEN_W  number of products to accumulate; sampled with start.
- prod  input  PROD_W  signed product from the multiplier.
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  block accepts prod this cycle.
- acc_out  output  ACC_W  signed accumulated result, registered.
- acc_valid  output  1  acc_out holds a finished result.
- acc_ready  input  1  consumer takes result.
- sat  output  1  sticky: saturation occurred during the current/last job.
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, remaining count=0, acc_out=0, acc_valid=0, prod_ready=0, sat=0, busy=0. Reset mid-job aborts the job; partial sum is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 with len!=0: clear acc and sat, load count=len, go to ACCUM.
  - start=1 with len=0: clear acc and sat, go directly to HOLD; acc_out=0 valid next cycle.
  - start=0: remain in IDLE; acc_out keeps the previous result.
- ACCUM:
  - prod_ready=1 combinationally in this state only.
  - Transfer occurs when prod_valid and prod_ready are both 1.
  - On each transfer: acc <= sat_clamp(acc + sign_extend(prod)); count decrements.
  - The sum is formed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Defaults: -512..511.
  - Clamping sets sat=1 (sticky until the next start). Accumulation continues from the clamped value.
  - Transfer that takes count to 0: go to HOLD. acc_out <= the new acc and acc_valid=1 in the next cycle, so latency is 1 cycle from the last accepted product.
  - prod_valid=0 cycles stall without change; no timeout.
- HOLD:
  - acc_valid=1 and acc_out is stable until acc_ready=1.
  - acc_valid and acc_ready both 1: acc_valid=0 next cycle, go to IDLE.
  - prod_ready=0.
- start outside IDLE is ignored, including start in the same cycle as the HOLD handshake. A new job requires start in IDLE, so there is at least one idle cycle between jobs.
- prod is treated as signed two's complement. Valid multiplier range is -56..64, but any PROD_W value is handled.
- No combinational path from prod_valid to prod_ready, or from acc_ready to acc_valid.

Test Plan:
- Reset/idle: assert rst_n=0 mid-ACCUM after 3 products -> all outputs 0 and state IDLE immediately. After release, start len=2 with prods 5,-3 -> acc_out=2, acc_valid one cycle after the 2nd transfer, sat=0.
- Basic dot product: len=4, prods 6 (2*3), -12 (-3*4), 49 (-7*-7), -56 (-8*7) with prod_valid held high -> prod_ready high for exactly 4 cycles, acc_out=-13, sat=0.
- Positive saturation: len=9, prod=64 each -> acc_out=511, sat=1. Separately len=7, prod=64 each -> acc_out=448, sat=0.
- Negative saturation with recovery: len=12, ten prods of -56 then two of +64 -> clamp at -512, final acc_out=-384, sat=1.
- Backpressure: len=3, prod_valid toggling 1,0,0,1,1 (prods 1,2,3), then acc_ready held low 5 cycles -> acc_out=6 held stable with acc_valid=1 for all 5 cycles. Start pulses during HOLD are ignored. Raise acc_ready -> acc_valid drops next cycle.
- Zero length: start with len=0 -> acc_valid=1 next cycle, acc_out=0, prod_ready never asserted, sat=0.
